// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath bundle: opcode/flags in, datapath controls out.
// master: controller side; slave: datapath side.
interface multi_cycle_controller_if #(
  parameter int OPCODE_W = 6,
  parameter int ALU_W    = 3
);
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;

  logic                pc_write;
  logic                ir_write;
  logic                i_or_d;
  logic                alu_src_a;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic                mem_read;
  logic                mem_write;
  logic [1:0]          alu_src_b;
  logic [1:0]          pc_src;
  logic [ALU_W-1:0]    alu_s;
  logic [3:0]          state;
  logic                instr_done;
  logic                illegal;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, i_or_d,
    output alu_src_a, reg_dst, mem_to_reg,
    output reg_write, mem_read, mem_write,
    output alu_src_b, pc_src, alu_s,
    output state, instr_done, illegal
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, i_or_d,
    input  alu_src_a, reg_dst, mem_to_reg,
    input  reg_write, mem_read, mem_write,
    input  alu_src_b, pc_src, alu_s,
    input  state, instr_done, illegal
  );
endinterface

// File: rtl/multi_cycle_controller.sv
// Multi-cycle CPU control FSM (fetch/decode/exec/mem/wb).
// Ports: clk, rst_n (async low), ctrl_if (master) carrying
//   opcode/zero/mem_ready in and all datapath controls out.
module multi_cycle_controller #(
  parameter int OPCODE_W      = 6,
  parameter int ALU_W         = 3,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic clk,
  input  logic rst_n,
  multi_cycle_controller_if.master ctrl_if
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_R_WB     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9
  } state_e;

  typedef struct packed {
    logic             pc_write;
    logic             ir_write;
    logic             i_or_d;
    logic             alu_src_a;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_src;
    logic [ALU_W-1:0] alu_s;
    logic             instr_done;
    logic             illegal;
  } ctl_t;

  localparam logic [OPCODE_W-1:0] OP_NOP = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_OR  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_SLT = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(9);
  localparam logic [OPCODE_W-1:0] OP_BNE = OPCODE_W'(10);

  localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
  localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
  localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(2);
  localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(3);
  localparam logic [ALU_W-1:0] ALU_LT  = ALU_W'(4);

  state_e state_q;
  state_e state_d;
  ctl_t   ctl;
  ctl_t   ctl_g;

  logic [OPCODE_W-1:0] op;
  logic rdy;
  logic is_r;
  logic is_mem;
  logic is_br;
  logic is_jmp;
  logic is_nop;
  logic is_bad;
  logic br_take;

  assign op  = ctrl_if.opcode;
  // With the handshake disabled every memory access is single-cycle.
  assign rdy = (MEM_HANDSHAKE == 0) ? 1'b1 : ctrl_if.mem_ready;

  assign is_r   = (op >= OP_ADD) && (op <= OP_SLT);
  assign is_mem = (op == OP_LW) || (op == OP_SW);
  assign is_br  = (op == OP_BEQ) || (op == OP_BNE);
  assign is_jmp = (op == OP_JMP);
  assign is_nop = (op == OP_NOP);
  assign is_bad = (op > OP_BNE);

  assign br_take = ((op == OP_BEQ) && ctrl_if.zero) ||
                   ((op == OP_BNE) && !ctrl_if.zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH: begin
        state_d = rdy ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_r:    state_d = S_EXEC_R;
          is_mem:  state_d = S_MEM_ADDR;
          is_br:   state_d = S_BRANCH;
          is_jmp:  state_d = S_JUMP;
          default: state_d = S_FETCH;
        endcase
      end
      S_EXEC_R: begin
        state_d = S_R_WB;
      end
      S_MEM_ADDR: begin
        state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        state_d = rdy ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WR: begin
        state_d = rdy ? S_FETCH : S_MEM_WR;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_comb begin
    ctl = '0;
    unique case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'd1;
        ctl.alu_s     = ALU_ADD;
        ctl.ir_write  = rdy;
        ctl.pc_write  = rdy;
      end
      S_DECODE: begin
        // Branch target is precomputed here and latched by the datapath.
        ctl.alu_src_b  = 2'd2;
        ctl.alu_s      = ALU_ADD;
        ctl.illegal    = is_bad;
        ctl.instr_done = is_bad || is_nop;
      end
      S_EXEC_R: begin
        ctl.alu_src_a = 1'b1;
        unique case (1'b1)
          op == OP_SUB: ctl.alu_s = ALU_SUB;
          op == OP_AND: ctl.alu_s = ALU_AND;
          op == OP_OR:  ctl.alu_s = ALU_OR;
          op == OP_SLT: ctl.alu_s = ALU_LT;
          default:      ctl.alu_s = ALU_ADD;
        endcase
      end
      S_R_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'd2;
        ctl.alu_s     = ALU_ADD;
      end
      S_MEM_RD: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctl.mem_write  = 1'b1;
        ctl.i_or_d     = 1'b1;
        ctl.instr_done = rdy;
      end
      S_BRANCH: begin
        ctl.alu_src_a  = 1'b1;
        ctl.alu_s      = ALU_SUB;
        ctl.pc_src     = 2'd1;
        ctl.pc_write   = br_take;
        ctl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_src     = 2'd2;
        ctl.pc_write   = 1'b1;
        ctl.instr_done = 1'b1;
      end
      default: begin
        ctl = '0;
      end
    endcase
  end

  // Reset clears outputs at once, not only after state settles.
  assign ctl_g = rst_n ? ctl : '0;

  assign ctrl_if.pc_write   = ctl_g.pc_write;
  assign ctrl_if.ir_write   = ctl_g.ir_write;
  assign ctrl_if.i_or_d     = ctl_g.i_or_d;
  assign ctrl_if.alu_src_a  = ctl_g.alu_src_a;
  assign ctrl_if.reg_dst    = ctl_g.reg_dst;
  assign ctrl_if.mem_to_reg = ctl_g.mem_to_reg;
  assign ctrl_if.reg_write  = ctl_g.reg_write;
  assign ctrl_if.mem_read   = ctl_g.mem_read;
  assign ctrl_if.mem_write  = ctl_g.mem_write;
  assign ctrl_if.alu_src_b  = ctl_g.alu_src_b;
  assign ctrl_if.pc_src     = ctl_g.pc_src;
  assign ctrl_if.alu_s      = ctl_g.alu_s;
  assign ctrl_if.instr_done = ctl_g.instr_done;
  assign ctrl_if.illegal    = ctl_g.illegal;
  assign ctrl_if.state      = state_q;

endmodule

// File: doc/multi_cycle_controller.md
MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL provide parameter OPCODE_W, default 6, opcode field width (min 4).
REQ-002 SHALL provide parameter ALU_W, default 3, ALU select width; codes add=0, sub=1, and=2, or=3, lt=4.
REQ-003 SHALL provide parameter MEM_HANDSHAKE, default 1; if 0, mem_ready is ignored and treated as 1.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; ports listed below.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 opcode  input  OPCODE_W  from instruction register; NOP=0, ADD=1, SUB=2, AND=3, OR=4, SLT=5, LW=6, SW=7, JMP=8, BEQ=9, BNE=10.
REQ-008 zero  input  1  ALU zero flag.
REQ-009 mem_ready  input  1  memory access completes this cycle.
REQ-010 pc_write, ir_write, i_or_d, alu_src_a, reg_dst, mem_to_reg, reg_write, mem_read, mem_write  output  1 each  datapath controls.
REQ-011 alu_src_b  output  2  0=reg B, 1=constant 1, 2=sign-extended immediate.
REQ-012 pc_src  output  2  0=ALU result, 1=latched branch target, 2=jump target.
REQ-013 alu_s  output  ALU_W  ALU operation.
REQ-014 state  output  4  current state encoding.
REQ-015 instr_done  output  1  one-cycle pulse on the last cycle of every instruction.
REQ-016 illegal  output  1  one-cycle pulse in DECODE for undefined opcode.

Function
REQ-017 States/encodings: FETCH=0, DECODE=1, EXEC_R=2, R_WB=3, MEM_ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, BRANCH=8, JUMP=9; codes 10-15 SHALL return to FETCH on next edge.
REQ-018 Outputs SHALL be combinational from state, opcode, zero and mem_ready; any output not listed for a state SHALL be 0.
REQ-019 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_s=add, pc_src=0; when mem_ready=1: ir_write=1, pc_write=1, go DECODE; else stay.
REQ-020 DECODE: alu_src_a=0, alu_src_b=2, alu_s=add (target precompute); next: ADD..SLT->EXEC_R, LW/SW->MEM_ADDR, BEQ/BNE->BRANCH, JMP->JUMP, NOP->FETCH with instr_done=1; opcode>10 -> FETCH with illegal=1 and instr_done=1.
REQ-021 EXEC_R: alu_src_a=1, alu_src_b=0, alu_s=add/sub/and/or/lt for ADD/SUB/AND/OR/SLT; next R_WB.
REQ-022 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; next FETCH.
REQ-023 MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_s=add; next MEM_RD for LW, MEM_WR for SW.
REQ-024 MEM_RD: mem_read=1, i_or_d=1; stay until mem_ready=1, then MEM_WB.
REQ-025 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1; next FETCH.
REQ-026 MEM_WR: mem_write=1, i_or_d=1; stay until mem_ready=1, then instr_done=1 and FETCH.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=0, alu_s=sub, pc_src=1, instr_done=1; pc_write=1 iff (BEQ and zero=1) or (BNE and zero=0); next FETCH.
REQ-028 JUMP: pc_src=2, pc_write=1, instr_done=1; next FETCH.
REQ-029 Latency with zero wait: NOP 2, JMP/BEQ/BNE 3, R-type 4, SW 4, LW 5 cycles; each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR adds one.
REQ-030 opcode SHALL be sampled only in DECODE through BRANCH/MEM_ADDR; changes during FETCH SHALL not affect outputs.

Reset
REQ-031 rst_n=0 SHALL immediately force state=FETCH and all outputs to 0 regardless of clock, including mid-instruction.
REQ-032 First edge after rst_n rises SHALL see FETCH behaviour (mem_read=1); no pulse of instr_done or illegal on reset release.

Verification
REQ-033 ADD, mem_ready=1 -> states 0,1,2,3,0; alu_s=0 in EXEC_R; reg_write=reg_dst=1 and instr_done=1 in cycle 4.
REQ-034 LW, mem_ready low 2 cycles in MEM_RD -> MEM_RD held 3 cycles, mem_read=i_or_d=1 throughout, then MEM_WB with mem_to_reg=1.
REQ-035 BEQ zero=1 -> pc_write=1, pc_src=1; BEQ zero=0 -> pc_write=0; BNE zero=0 -> pc_write=1.
REQ-036 opcode=15 -> DECODE pulses illegal=1, instr_done=1, next state FETCH, no reg_write/mem_write.
REQ-037 rst_n low mid MEM_WR -> mem_write drops to 0 same cycle, state=0; after release, FETCH with mem_read=1.
REQ-038 MEM_HANDSHAKE=0, mem_ready held 0 -> SW completes in 4 cycles.
